audio_fifo_reader: RTL



---
 rtl/audio_pkg.sv | 16 +
 rtl/sample_tick_gen.sv | 38 +++
 rtl/audio_fifo_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio playback path: FSM encoding and default
// sample-rate / idle-level values.
package audio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_RUN   = 3'd2,
      ST_READ  = 3'd3,
      ST_LATCH = 3'd4
   } state_e;

   localparam logic [7:0]  IDLE_SAMPLE_DEF = 8'h80;
   localparam int unsigned CLK_DIV_48K     = 2083;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: emits a one-cycle tick every CLK_DIV
// clocks while enabled, and returns to zero whenever clr is high.
module sample_tick_gen
   import audio_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_48K
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/audio_fifo_reader.sv
// Drains the audio FIFO at the sample rate and holds each byte for the PWM
// stage; primes before playback, counts underruns and requests refills.
module audio_fifo_reader
   import audio_pkg::*;
#(
   parameter int unsigned       CLK_DIV     = CLK_DIV_48K,
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       CNT_W       = 11,
   parameter int unsigned       PRIME_LEVEL = 1024,
   parameter int unsigned       LOW_WATER   = 512,
   parameter logic [DATA_W-1:0] IDLE_SAMPLE = DATA_W'(IDLE_SAMPLE_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   input  logic [CNT_W-1:0]  fifo_count,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              refill_req,
   output logic              underrun,
   output logic [15:0]       underrun_count,
   output logic [2:0]        state_dbg
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic              sample_valid_q, sample_valid_d;
   logic              underrun_q, underrun_d;
   logic [15:0]       underrun_count_q, underrun_count_d;
   logic              refill_req_q, refill_req_d;
   logic              tick, tick_en;
   logic [31:0]       count_ext;

   assign count_ext = 32'(fifo_count);
   assign tick_en   = state_q inside {ST_RUN, ST_READ, ST_LATCH};

   sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (tick_en),
      .clr   (!tick_en),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         sample_q         <= IDLE_SAMPLE;
         sample_valid_q   <= 1'b0;
         underrun_q       <= 1'b0;
         underrun_count_q <= '0;
         refill_req_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         sample_q         <= sample_d;
         sample_valid_q   <= sample_valid_d;
         underrun_q       <= underrun_d;
         underrun_count_q <= underrun_count_d;
         refill_req_q     <= refill_req_d;
      end
   end

   // READ and LATCH ignore enable so a started read always completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_PRIME;
         ST_PRIME: begin
            if (!enable)                        state_d = ST_IDLE;
            else if (count_ext >= PRIME_LEVEL)  state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable)                  state_d = ST_IDLE;
            else if (tick && !fifo_empty) state_d = ST_READ;
         end
         ST_READ:  state_d = ST_LATCH;
         ST_LATCH: state_d = enable ? ST_RUN : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_rd_en       = (state_q == ST_READ);
      sample_d         = sample_q;
      sample_valid_d   = 1'b0;
      underrun_d       = 1'b0;
      underrun_count_d = underrun_count_q;
      refill_req_d     = (count_ext < LOW_WATER);
      case (state_q)
         ST_IDLE: sample_d = IDLE_SAMPLE;
         ST_RUN: begin
            if (!enable) begin
               sample_d = IDLE_SAMPLE;
            end else if (tick && fifo_empty) begin
               sample_d   = IDLE_SAMPLE;
               underrun_d = 1'b1;
               if (underrun_count_q != 16'hFFFF) underrun_count_d = underrun_count_q + 16'd1;
            end
         end
         ST_LATCH: begin
            sample_d       = fifo_dout;
            sample_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign sample         = sample_q;
   assign sample_valid   = sample_valid_q;
   assign underrun       = underrun_q;
   assign underrun_count = underrun_count_q;
   assign refill_req     = refill_req_q;
   assign state_dbg      = state_q;

endmodule
